// File: rtl/voq_ptr_queue_if.sv
// Bundle between the crossbar/egress scheduler and the VOQ pointer bank.
interface voq_ptr_queue_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 12,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 16
);
  localparam int PTR_W = $clog2(DEPTH) + 1;

  logic [NUM_PORTS-1:0] write_reqs;
  logic [ADDR_W-1:0]    start_ptrs [NUM_PORTS-1:0];
  logic [NUM_PORTS-1:0] deq_ready;
  logic [NUM_PORTS-1:0] deq_valid;
  logic [ADDR_W-1:0]    deq_ptrs   [NUM_PORTS-1:0];
  logic [PTR_W-1:0]     occupancy  [NUM_PORTS-1:0];
  logic [NUM_PORTS-1:0] drop;
  logic [CNT_W-1:0]     drop_count;

  // crossbar + scheduler side
  modport master (
    output write_reqs, start_ptrs, deq_ready,
    input  deq_valid, deq_ptrs, occupancy, drop, drop_count
  );

  // queue bank side
  modport slave (
    input  write_reqs, start_ptrs, deq_ready,
    output deq_valid, deq_ptrs, occupancy, drop, drop_count
  );
endinterface

// File: rtl/voq_ptr_queue.sv
// Per-ingress VOQ bank: one circular pointer FIFO per egress port, with
// drop-on-full and a saturating drop counter.

// One egress FIFO. Pointers carry an extra wrap bit to tell full from empty.
module voq_lane #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_req,
  input  logic [ADDR_W-1:0]        wr_ptr,
  input  logic                     deq_ready,
  output logic                     valid,
  output logic [ADDR_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   occ,
  output logic                     drop_now,
  output logic                     drop
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr, rd;
  logic              empty, full, deq_fire, enq;

  assign empty    = (wr == rd);
  assign full     = (wr[IDX_W-1:0] == rd[IDX_W-1:0]) && (wr[PTR_W-1] != rd[PTR_W-1]);
  assign deq_fire = !empty && deq_ready;
  // a full FIFO still takes a write when its head leaves in the same cycle
  assign enq      = wr_req && (!full || deq_fire);
  assign drop_now = wr_req && full && !deq_fire;

  assign valid = !empty;
  assign head  = empty ? '0 : mem[rd[IDX_W-1:0]];
  assign occ   = wr - rd;

  // pointer and drop-flag state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr   <= '0;
      rd   <= '0;
      drop <= 1'b0;
    end else begin
      wr   <= wr + PTR_W'(enq);
      rd   <= rd + PTR_W'(deq_fire);
      drop <= drop_now;
    end
  end

  // storage is deliberately not reset; head is gated while empty
  always_ff @(posedge clk) begin
    if (rst_n && enq) mem[wr[IDX_W-1:0]] <= wr_ptr;
  end
endmodule

module voq_ptr_queue #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 12,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  voq_ptr_queue_if.slave      bus
);
  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + $clog2(NUM_PORTS + 1);

  logic [NUM_PORTS-1:0] valid, drop_now, drop;
  logic [ADDR_W-1:0]    head [NUM_PORTS-1:0];
  logic [PTR_W-1:0]     occ  [NUM_PORTS-1:0];
  logic [CNT_W-1:0]     cnt;
  logic [SUM_W-1:0]     ndrop, sum;

  for (genvar q = 0; q < NUM_PORTS; q++) begin : g_lane
    voq_lane #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_req    (bus.write_reqs[q]),
      .wr_ptr    (bus.start_ptrs[q]),
      .deq_ready (bus.deq_ready[q]),
      .valid     (valid[q]),
      .head      (head[q]),
      .occ       (occ[q]),
      .drop_now  (drop_now[q]),
      .drop      (drop[q])
    );
  end

  // popcount of this cycle's drops, widened so the sum cannot overflow
  always_comb begin
    ndrop = '0;
    for (int q = 0; q < NUM_PORTS; q++) ndrop = ndrop + SUM_W'(drop_now[q]);
    sum = SUM_W'(cnt) + ndrop;
  end

  // saturating drop counter
  always_ff @(posedge clk) begin
    if (!rst_n)                               cnt <= '0;
    else if (sum > SUM_W'({CNT_W{1'b1}}))     cnt <= '1;
    else                                      cnt <= sum[CNT_W-1:0];
  end

  assign bus.deq_valid  = valid;
  assign bus.deq_ptrs   = head;
  assign bus.occupancy  = occ;
  assign bus.drop       = drop;
  assign bus.drop_count = cnt;
endmodule

// File: tb/tb_voq_ptr_queue.sv
// Directed bench for voq_ptr_queue: default instance plus a CNT_W=4 instance
// for counter saturation.
module tb_voq_ptr_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  voq_ptr_queue_if #(.NUM_PORTS(4), .ADDR_W(12), .DEPTH(8), .CNT_W(16)) b ();
  voq_ptr_queue_if #(.NUM_PORTS(4), .ADDR_W(12), .DEPTH(8), .CNT_W(4))  s ();

  voq_ptr_queue #(.NUM_PORTS(4), .ADDR_W(12), .DEPTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b.slave));
  voq_ptr_queue #(.NUM_PORTS(4), .ADDR_W(12), .DEPTH(8), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(s.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one edge, then settle away from it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b.write_reqs = '0;
    b.deq_ready  = '0;
    s.write_reqs = '0;
    s.deq_ready  = '0;
    for (int q = 0; q < 4; q++) begin
      b.start_ptrs[q] = '0;
      s.start_ptrs[q] = '0;
    end
  endtask

  initial begin
    idle();
    cyc();
    cyc();
    // reset state
    chk("rst_valid", 32'(b.deq_valid), 32'h0);
    chk("rst_ptr0",  32'(b.deq_ptrs[0]), 32'h0);
    chk("rst_occ3",  32'(b.occupancy[3]), 32'h0);
    chk("rst_drop",  32'(b.drop), 32'h0);
    chk("rst_cnt",   32'(b.drop_count), 32'h0);
    rst_n = 1'b1;

    // single write to FIFO 2
    b.write_reqs = 4'b0100;
    b.start_ptrs[2] = 12'h010;
    cyc();
    idle();
    chk("w2_valid", 32'(b.deq_valid), 32'h4);
    chk("w2_ptr",   32'(b.deq_ptrs[2]), 32'h010);
    chk("w2_occ",   32'(b.occupancy[2]), 32'h1);
    chk("w2_ptr0",  32'(b.deq_ptrs[0]), 32'h0);
    chk("w2_occ1",  32'(b.occupancy[1]), 32'h0);
    chk("w2_drop",  32'(b.drop), 32'h0);
    b.deq_ready = 4'b0100;
    cyc();
    idle();
    chk("w2_drain", 32'(b.deq_valid), 32'h0);

    // broadcast, held with ready low, then one accepting cycle
    b.write_reqs = 4'b1111;
    for (int q = 0; q < 4; q++) b.start_ptrs[q] = 12'hA00 + 12'(q);
    cyc();
    idle();
    cyc();
    chk("bc_valid", 32'(b.deq_valid), 32'hF);
    for (int q = 0; q < 4; q++) begin
      chk($sformatf("bc_ptr%0d", q), 32'(b.deq_ptrs[q]), 32'hA00 + 32'(q));
      chk($sformatf("bc_occ%0d", q), 32'(b.occupancy[q]), 32'h1);
    end
    b.deq_ready = 4'b1111;
    cyc();
    idle();
    chk("bc_empty", 32'(b.deq_valid), 32'h0);
    chk("bc_ptr1z", 32'(b.deq_ptrs[1]), 32'h0);

    // fill FIFO 0 past capacity
    for (int i = 1; i <= 10; i++) begin
      b.write_reqs = 4'b0001;
      b.start_ptrs[0] = 12'(i);
      cyc();
      chk($sformatf("fill_drop%0d", i), 32'(b.drop[0]), (i > 8) ? 32'h1 : 32'h0);
    end
    idle();
    chk("fill_occ", 32'(b.occupancy[0]), 32'h8);
    chk("fill_cnt", 32'(b.drop_count), 32'h2);
    cyc();
    chk("fill_dropclr", 32'(b.drop), 32'h0);
    b.deq_ready = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain_%0d", k), 32'(b.deq_ptrs[0]), 32'(k));
      cyc();
    end
    idle();
    chk("drain_empty", 32'(b.deq_valid[0]), 32'h0);
    // second pass crosses the index wrap
    for (int i = 11; i <= 18; i++) begin
      b.write_reqs = 4'b0001;
      b.start_ptrs[0] = 12'(i);
      cyc();
    end
    idle();
    chk("wrap_occ", 32'(b.occupancy[0]), 32'h8);
    b.deq_ready = 4'b0001;
    for (int k = 11; k <= 18; k++) begin
      chk($sformatf("wrap_%0d", k), 32'(b.deq_ptrs[0]), 32'(k));
      cyc();
    end
    idle();
    chk("wrap_empty", 32'(b.occupancy[0]), 32'h0);

    // full FIFO 1 with a same-cycle enqueue and dequeue
    for (int i = 1; i <= 8; i++) begin
      b.write_reqs = 4'b0010;
      b.start_ptrs[1] = 12'(i);
      cyc();
    end
    b.write_reqs = 4'b0010;
    b.start_ptrs[1] = 12'd9;
    b.deq_ready = 4'b0010;
    cyc();
    idle();
    chk("fd_drop", 32'(b.drop[1]), 32'h0);
    chk("fd_occ",  32'(b.occupancy[1]), 32'h8);
    chk("fd_head", 32'(b.deq_ptrs[1]), 32'h2);
    chk("fd_cnt",  32'(b.drop_count), 32'h2);
    cyc();
    chk("fd_hold", 32'(b.deq_ptrs[1]), 32'h2);
    b.deq_ready = 4'b0010;
    for (int k = 2; k <= 9; k++) begin
      chk($sformatf("fd_%0d", k), 32'(b.deq_ptrs[1]), 32'(k));
      cyc();
    end
    idle();
    chk("fd_empty", 32'(b.deq_valid), 32'h0);

    // multi-drop with a 4-bit counter
    for (int i = 0; i < 8; i++) begin
      s.write_reqs = 4'b1111;
      for (int q = 0; q < 4; q++) s.start_ptrs[q] = 12'(16 * q + i);
      cyc();
    end
    chk("sat_nodrop", 32'(s.drop_count), 32'h0);
    for (int i = 1; i <= 4; i++) begin
      s.write_reqs = 4'b1111;
      cyc();
      chk($sformatf("sat_drop%0d", i), 32'(s.drop), 32'hF);
      chk($sformatf("sat_cnt%0d", i), 32'(s.drop_count), (i == 4) ? 32'd15 : 32'(4 * i));
    end
    idle();
    cyc();
    chk("sat_hold", 32'(s.drop_count), 32'd15);
    chk("sat_dropclr", 32'(s.drop), 32'h0);
    chk("sat_occ2", 32'(s.occupancy[2]), 32'h8);
    chk("sat_head3", 32'(s.deq_ptrs[3]), 32'd48);

    // reset mid-operation, writes presented during the reset edge
    for (int i = 0; i < 2; i++) begin
      b.write_reqs = 4'b1001;
      b.start_ptrs[0] = 12'h111;
      b.start_ptrs[3] = 12'h333;
      cyc();
    end
    chk("mr_pre", 32'(b.occupancy[3]), 32'h2);
    rst_n = 1'b0;
    b.write_reqs = 4'b1111;
    for (int q = 0; q < 4; q++) b.start_ptrs[q] = 12'h777;
    cyc();
    rst_n = 1'b1;
    idle();
    chk("mr_valid", 32'(b.deq_valid), 32'h0);
    chk("mr_occ0",  32'(b.occupancy[0]), 32'h0);
    chk("mr_ptr3",  32'(b.deq_ptrs[3]), 32'h0);
    chk("mr_cnt",   32'(b.drop_count), 32'h0);
    chk("mr_scnt",  32'(s.drop_count), 32'h0);
    b.write_reqs = 4'b1000;
    b.start_ptrs[3] = 12'h0BE;
    cyc();
    idle();
    chk("mr_new_valid", 32'(b.deq_valid), 32'h8);
    chk("mr_new_ptr",   32'(b.deq_ptrs[3]), 32'h0BE);
    chk("mr_new_occ",   32'(b.occupancy[3]), 32'h1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
